// File: rtl/fetch_decode_queue_if.sv
// Handshake bundle between fetch, the instruction queue and decode.
// The queue binds the slave modport; the fetch/decode side binds master.
interface fetch_decode_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_ready;
    logic            flush;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, count, full, empty
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, count, full, empty
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// In-order fetch-to-decode instruction queue with flush on redirect.
// Optional macro FETCHQ_BYPASS_EN: zero-latency pass-through when empty.
module fetch_decode_queue #(
    parameter int              DEPTH     = 4,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
    input logic                 clk,
    input logic                 reset,
    fetch_decode_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic   empty_w;
    logic   full_w;
    logic   push;
    logic   pop;
    logic   bypass;
    entry_t head;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));
    assign head    = mem_q[rd_ptr_q];

`ifdef FETCHQ_BYPASS_EN
    assign bypass = empty_w && q.in_valid && q.out_ready && !q.flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed pair is consumed directly, so it is never written.
    assign push = q.in_valid && !full_w && !q.flush && !bypass;
    assign pop  = !empty_w && q.out_ready && !q.flush;

    assign q.in_ready = !full_w;
    assign q.full     = full_w;
    assign q.empty    = empty_w;
    assign q.count    = count_q;

    always_comb begin
        q.out_valid = 1'b0;
        q.out_pc    = '0;
        q.out_instr = NOP_INSTR;
        if (!q.flush) begin
            if (!empty_w) begin
                q.out_valid = 1'b1;
                q.out_pc    = head.pc;
                q.out_instr = head.instr;
            end
`ifdef FETCHQ_BYPASS_EN
            else if (bypass) begin
                q.out_valid = 1'b1;
                q.out_pc    = q.in_pc;
                q.out_instr = q.in_instr;
            end
`endif
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: q.in_pc, instr: q.in_instr};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (DEPTH=4, XLEN=32).
// Bypass expectations follow FETCHQ_BYPASS_EN.
module tb_fetch_decode_queue;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fetch_decode_queue_if #(.DEPTH(4), .XLEN(32)) fq ();

    fetch_decode_queue #(
        .DEPTH(4), .XLEN(32), .NOP_INSTR(NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .q    (fq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic rdy,
                         input logic fl);
        fq.in_valid  = v;
        fq.in_pc     = pc;
        fq.in_instr  = ins;
        fq.out_ready = rdy;
        fq.flush     = fl;
        #1;
    endtask

    logic [31:0] fill_ins [4];

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_ins[0] = 32'h00500093;
        fill_ins[1] = 32'h00A00113;
        fill_ins[2] = 32'h002081B3;
        fill_ins[3] = 32'h00000013;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rst_count", 32'(fq.count), 32'd0);
        chk("rst_empty", 32'(fq.empty), 32'd1);
        chk("rst_full", 32'(fq.full), 32'd0);
        chk("rst_ready", 32'(fq.in_ready), 32'd1);
        chk("rst_valid", 32'(fq.out_valid), 32'd0);
        chk("rst_pc", fq.out_pc, 32'h0);
        chk("rst_instr", fq.out_instr, NOP);
        tick();
        reset = 1'b0;

        // fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), fill_ins[i], 1'b0, 1'b0);
            tick();
            if (i == 0) begin
                chk("lat_valid", 32'(fq.out_valid), 32'd1);
                chk("lat_pc", fq.out_pc, 32'h0);
            end
        end
        chk("fill_full", 32'(fq.full), 32'd1);
        chk("fill_ready", 32'(fq.in_ready), 32'd0);
        chk("fill_count", 32'(fq.count), 32'd4);
        drive(1'b1, 32'h10, 32'hDEAD0010, 1'b0, 1'b0);
        tick();
        chk("rej_count", 32'(fq.count), 32'd4);
        chk("rej_pc", fq.out_pc, 32'h0);

        // full with both sides active: pop only
        drive(1'b1, 32'h10, 32'hDEAD0010, 1'b1, 1'b0);
        chk("drain_pc0", fq.out_pc, 32'h0);
        chk("drain_in0", fq.out_instr, fill_ins[0]);
        tick();
        chk("fp_count", 32'(fq.count), 32'd3);
        chk("fp_ready", 32'(fq.in_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            chk($sformatf("drain_pc%0d", i), fq.out_pc, 32'(i * 4));
            chk($sformatf("drain_in%0d", i), fq.out_instr, fill_ins[i]);
            tick();
        end
        chk("drain_empty", 32'(fq.empty), 32'd1);
        chk("drain_valid", 32'(fq.out_valid), 32'd0);
        chk("drain_nop", fq.out_instr, NOP);
        chk("drain_pcz", fq.out_pc, 32'h0);

        // streaming push+pop across pointer wrap
        drive(1'b1, 32'h0, 32'hA0000000, 1'b0, 1'b0);
        tick();
        for (int k = 1; k < 10; k++) begin
            drive(1'b1, 32'(k * 4), 32'hA0000000 | 32'(k * 4), 1'b1, 1'b0);
            chk($sformatf("strm_pc%0d", k - 1), fq.out_pc, 32'((k - 1) * 4));
            chk($sformatf("strm_in%0d", k - 1), fq.out_instr,
                32'hA0000000 | 32'((k - 1) * 4));
            chk($sformatf("strm_cnt%0d", k), 32'(fq.count), 32'd1);
            tick();
        end
        chk("strm_last", fq.out_pc, 32'h24);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("strm_empty", 32'(fq.empty), 32'd1);

        // flush discards queued entries and the incoming one
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h10 + 32'(i * 4), 32'hB0000000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        chk("fl_pre_count", 32'(fq.count), 32'd3);
        drive(1'b1, 32'h1C, 32'hB0000003, 1'b1, 1'b1);
        chk("fl_valid", 32'(fq.out_valid), 32'd0);
        chk("fl_instr", fq.out_instr, NOP);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("fl_count", 32'(fq.count), 32'd0);
        chk("fl_empty", 32'(fq.empty), 32'd1);
        drive(1'b1, 32'h40, 32'hB0000040, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("fl_new_pc", fq.out_pc, 32'h40);
        chk("fl_new_cnt", 32'(fq.count), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("fl_new_pop", 32'(fq.empty), 32'd1);

        // empty with push and pop requested together
        drive(1'b1, 32'h80, 32'hC0000080, 1'b1, 1'b0);
`ifdef FETCHQ_BYPASS_EN
        chk("byp_valid", 32'(fq.out_valid), 32'd1);
        chk("byp_pc", fq.out_pc, 32'h80);
        chk("byp_instr", fq.out_instr, 32'hC0000080);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("byp_count", 32'(fq.count), 32'd0);
        chk("byp_empty", 32'(fq.empty), 32'd1);
`else
        chk("nbp_valid", 32'(fq.out_valid), 32'd0);
        chk("nbp_instr", fq.out_instr, NOP);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("nbp_valid1", 32'(fq.out_valid), 32'd1);
        chk("nbp_pc1", fq.out_pc, 32'h80);
        chk("nbp_count", 32'(fq.count), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("nbp_empty", 32'(fq.empty), 32'd1);
`endif

        // asynchronous reset while holding two entries
        drive(1'b1, 32'h100, 32'hD0000100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h104, 32'hD0000104, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("ar_pre_cnt", 32'(fq.count), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_count", 32'(fq.count), 32'd0);
        chk("ar_empty", 32'(fq.empty), 32'd1);
        chk("ar_valid", 32'(fq.out_valid), 32'd0);
        chk("ar_instr", fq.out_instr, NOP);
        chk("ar_ready", 32'(fq.in_ready), 32'd1);
        chk("ar_pc", fq.out_pc, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar_hold", 32'(fq.count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Small instruction queue between the fetch stage and the decode stage.
- Accepts (pc, instruction) pairs from fetch using a valid/ready handshake and presents them in order to decode.
- Fetch keeps running while decode stalls.
- Taken branch or jump flushes all queued (wrong-path) entries.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, >= 2.
- XLEN, 32, width of pc and instruction fields.
- NOP_INSTR, 32'h00000013, value driven on out_instr when the queue presents nothing (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_pc  input  XLEN  pc of the presented instruction (current_pc from fetch).
- in_instr  input  XLEN  fetched instruction word.
- in_ready  output  1  queue can accept this cycle.
- out_valid  output  1  head entry is valid for decode.
- out_pc  output  XLEN  pc of head entry.
- out_instr  output  XLEN  instruction of head entry; NOP_INSTR when out_valid=0.
- out_ready  input  1  decode consumes head this cycle.
- flush  input  1  discard all entries (branch/jump redirect).
- count  output  $clog2(DEPTH)+1  number of valid entries.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.

Behaviour:
- Reset (async, immediate):
  - wr_ptr, rd_ptr = 0; count = 0; all storage entries cleared to 0.
  - Outputs: out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1, full=0, empty=1.
- Storage:
  - DEPTH-entry register array of {pc, instr}.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: in_valid && in_ready && !flush. Writes entry at wr_ptr, then wr_ptr+1.
- Pop: out_valid && out_ready && !flush. rd_ptr+1.
- Count update: count' = count + push - pop. A simultaneous push and pop leaves count unchanged.
- Ready:
  - in_ready = !full. Combinational from registered count only; no path from out_ready.
  - When full, an in_valid instruction is not accepted. Fetch must hold it; the queue never overwrites.
- Output:
  - out_valid = !empty.
  - out_pc/out_instr read combinationally from entry rd_ptr.
  - When empty: out_pc=0, out_instr=NOP_INSTR.
- Latency: an instruction pushed in cycle N is visible on the outputs in cycle N+1.
- Flush:
  - Highest priority. On a clock edge with flush=1: wr_ptr = rd_ptr = 0, count = 0.
  - Any push or pop in that cycle is ignored; the in_valid instruction is dropped.
  - out_valid is forced to 0 combinationally while flush=1, so decode never consumes a wrong-path entry.
- Boundaries:
  - Full with out_ready=1 and in_valid=1: pop occurs, push rejected (in_ready=0). Next cycle count=DEPTH-1, in_ready=1.
  - Empty with in_valid=1 and out_ready=1: push only, no pop. Next cycle out_valid=1.
  - Wrap-around: order is preserved across pointer wrap.
  - Reset asserted mid-operation: all entries are lost immediately; outputs return to reset values with no clock required.
- No X propagation: out_pc/out_instr are never undefined after reset.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined:
  - When the queue is empty, in_valid=1, out_ready=1 and flush=0, the input passes straight through combinationally: out_valid=1, out_pc=in_pc, out_instr=in_instr. The pair is consumed without being stored, so count stays 0. Latency is 0 cycles.
  - If empty and out_ready=0, normal push.
  - in_ready is unchanged (still !full).
- Not defined: 1-cycle minimum latency, as in Behaviour; no combinational path from in_* to out_*.

Test Plan:
- Reset: assert reset mid-cycle with 2 entries held -> immediately count=0, empty=1, out_valid=0, out_instr=32'h00000013, in_ready=1.
- Fill: DEPTH=4, out_ready=0, push pc 0x00,0x04,0x08,0x0C with instrs 0x00500093,0x00A00113,0x002081B3,0x00000013 -> after 4th edge full=1, in_ready=0, count=4. A 5th push (pc 0x10) is rejected; out_pc remains 0x00.
- Drain in order: from full, out_ready=1 for 4 cycles -> out_pc sequence 0x00,0x04,0x08,0x0C with matching instrs; then empty=1, out_instr=NOP.
- Simultaneous push/pop with wrap: stream 10 instrs (pc 0x00..0x24) with in_valid=out_ready=1 continuously after 1 preload -> count stays 1, order preserved across pointer wrap, no drops.
- Flush: queue holds pc 0x10,0x14,0x18; assert flush with in_valid=1, pc 0x1C -> out_valid=0 during the flush cycle; next cycle count=0 and pc 0x1C is not stored. Push pc 0x40 next -> out_pc=0x40 one cycle later.
- Bypass (FETCHQ_BYPASS_EN): empty, in_valid=1, pc 0x80, out_ready=1 -> same cycle out_valid=1, out_pc=0x80, count stays 0. Without the macro -> out_valid=0 that cycle; pc 0x80 appears next cycle.
